// File: rtl/window_3x3_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_gen_pkg
// Description : Shared constants and helpers for the 3x3 window generator.
//               - C_DATA_WIDTH : default pixel width
//               - C_K          : window edge length
//               - win_idx()    : element slot of (r,c) inside a packed window,
//                                top-left element in the most significant slot
//               - padded_dim() : padded map dimension for a given pad size
// Revision    : 1.0 - initial release
// ============================================================================
package window_3x3_gen_pkg;

    localparam int C_DATA_WIDTH = 8;
    localparam int C_K          = 3;
    localparam int C_ORIG_DIM   = 32;
    localparam int C_PAD        = 1;

    // Slot index of window element (r,c); slot 8 is the MSB slot.
    function automatic int win_idx(input int r, input int c);
        return (C_K * C_K - 1) - (C_K * r + c);
    endfunction

    // Padded dimension: original dimension plus padding on both sides.
    function automatic int padded_dim(input int n, input int p);
        return n + 2 * p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_3x3_gen_line_delay.sv
`default_nettype none
// ============================================================================
// Module      : line_delay
// Description : DATA_WIDTH x DEPTH delay line built as a circular RAM with a
//               single read/write pointer. dout presents the value written
//               DEPTH enabled cycles ago; on an enabled edge that slot is
//               overwritten with din and the pointer advances.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset (pointer only)
//               en   - advance the delay line
//               din  - value entering the line
//               dout - value written DEPTH enables earlier
// Revision    : 1.0 - initial release
// ============================================================================
module line_delay #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 34
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] C_PTR_MAX = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_ptr;

    // Read-before-write: the slot about to be overwritten holds the oldest
    // value, which is exactly the DEPTH-cycle delayed sample.
    assign dout = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (en) begin
            r_ptr <= (r_ptr == C_PTR_MAX) ? '0 : r_ptr + PTR_W'(1);
        end
    end

    // Contents need no reset: two full rows are written before any window
    // depending on them is emitted.
    always_ff @(posedge clk) begin
        if (en) begin
            r_mem[r_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_3x3_gen.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3_gen
// Description : Streaming 3x3 sliding-window generator for a zero-padded
//               W x H map delivered one pixel per cycle in raster order.
//               Two line delays supply the pixels one and two rows above the
//               incoming pixel; a small history register holds the previous
//               two columns. A one-entry output stage presents each complete
//               window (bottom-right pixel at row>=2, col>=2).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_valid/in_ready - pixel handshake, in_data the pixel
//               out_valid/out_ready - window handshake
//               out_window        - 9 pixels, element (r,c) at slot 8-(3r+c)
//               out_last          - final window of the frame
// Revision    : 1.0 - initial release
// ============================================================================
module window_3x3_gen
    import window_3x3_gen_pkg::*;
#(
    parameter int W          = padded_dim(C_ORIG_DIM, C_PAD),
    parameter int H          = padded_dim(C_ORIG_DIM, C_PAD),
    parameter int DATA_WIDTH = C_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [9*DATA_WIDTH-1:0]   out_window,
    output logic                      out_last
);

    localparam int               COL_W     = (W > 1) ? $clog2(W) : 1;
    localparam int               ROW_W     = (H > 1) ? $clog2(H) : 1;
    localparam logic [COL_W-1:0] C_COL_MAX = COL_W'(W - 1);
    localparam logic [ROW_W-1:0] C_ROW_MAX = ROW_W'(H - 1);
    localparam logic [COL_W-1:0] C_COL_MIN = COL_W'(C_K - 1);
    localparam logic [ROW_W-1:0] C_ROW_MIN = ROW_W'(C_K - 1);

    // Position of the next pixel to be accepted.
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    logic w_accept;
    logic w_consume;
    logic w_col_end;
    logic w_row_end;
    logic w_emit;

    logic [DATA_WIDTH-1:0] w_lb0_out;
    logic [DATA_WIDTH-1:0] w_lb1_out;

    // Left two columns of the window; the right column is formed live from
    // the line delays and the incoming pixel, so it needs no storage.
    logic [DATA_WIDTH-1:0] r_hist [C_K][C_K-1];
    logic [DATA_WIDTH-1:0] w_new_col [C_K];
    logic [9*DATA_WIDTH-1:0] w_window;

    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = out_valid && out_ready;
    assign w_col_end = (r_col == C_COL_MAX);
    assign w_row_end = (r_row == C_ROW_MAX);
    // Right column at col 0/1 would straddle two rows: suppressed.
    assign w_emit    = (r_row >= C_ROW_MIN) && (r_col >= C_COL_MIN);

    line_delay #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (W)
    ) u_lb0 (
        .clk  (clk),
        .rst  (rst),
        .en   (w_accept),
        .din  (in_data),
        .dout (w_lb0_out)
    );

    line_delay #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (W)
    ) u_lb1 (
        .clk  (clk),
        .rst  (rst),
        .en   (w_accept),
        .din  (w_lb0_out),
        .dout (w_lb1_out)
    );

    always_comb begin
        w_new_col[0] = w_lb1_out;
        w_new_col[1] = w_lb0_out;
        w_new_col[2] = in_data;
    end

    // Window as it will look once the current pixel is shifted in.
    always_comb begin
        w_window = '0;
        for (int r = 0; r < C_K; r++) begin
            for (int c = 0; c < C_K - 1; c++) begin
                w_window[DATA_WIDTH*win_idx(r, c) +: DATA_WIDTH] = r_hist[r][c];
            end
            w_window[DATA_WIDTH*win_idx(r, C_K-1) +: DATA_WIDTH] = w_new_col[r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < C_K; r++) begin
                r_hist[r][0] <= r_hist[r][1];
                r_hist[r][1] <= w_new_col[r];
            end
        end
    end

    // One-entry output stage. Loading is only possible when in_ready, i.e.
    // when the slot is empty or being drained this very cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_window <= '0;
        end else if (w_accept && w_emit) begin
            out_valid  <= 1'b1;
            out_last   <= w_row_end && w_col_end;
            out_window <= w_window;
        end else if (w_consume) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire
